// File: rtl/vstream_meter.sv
// Receive-side monitor for the di/de/hs/vs pixel stream: measures frame geometry,
// sums pixel components per frame and flags protocol violations, reported once per frame.
module vstream_meter #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int DI_COUNT        = 3,
    parameter int LINE_SIZE_MAX   = 4096,
    parameter int FRAME_LINES_MAX = 4096,
    localparam int W_W = $clog2(LINE_SIZE_MAX + 1),
    localparam int H_W = $clog2(FRAME_LINES_MAX + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PIXEL_WIDTH*DI_COUNT-1:0] di_i,
    input  logic                            de_i,
    input  logic                            hs_i,
    input  logic                            vs_i,
    output logic [W_W-1:0]                  frame_w_o,
    output logic [H_W-1:0]                  frame_h_o,
    output logic [31:0]                     checksum_o,
    output logic [3:0]                      frame_err_o,
    output logic [15:0]                     frame_cnt_o,
    output logic                            frame_done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_LINE  = 2'd2
    } state_t;

    localparam logic [W_W-1:0] PIX_MAX  = W_W'(LINE_SIZE_MAX);
    localparam logic [H_W-1:0] LINE_MAX = H_W'(FRAME_LINES_MAX);

    function automatic logic [31:0] pix_sum(input logic [PIXEL_WIDTH*DI_COUNT-1:0] di);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < DI_COUNT; k++) begin
            s = s + 32'(di[k*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
        return s;
    endfunction

    state_t         state_q, state_d;
    logic           hs_prev_q, vs_prev_q;
    logic           armed_q, armed_d;
    logic           seen_q, seen_d;
    logic [W_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [H_W-1:0] line_cnt_q, line_cnt_d;
    logic [W_W-1:0] ref_w_q, ref_w_d;
    logic [31:0]    acc_q, acc_d;
    logic [3:0]     err_q, err_d;
    logic [W_W-1:0] frame_w_q, frame_w_d;
    logic [H_W-1:0] frame_h_q, frame_h_d;
    logic [31:0]    checksum_q, checksum_d;
    logic [3:0]     frame_err_q, frame_err_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           frame_done_q, frame_done_d;

    logic hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s;
    logic count_s, close_s, eof_s, trunc_s, de_err_s;

    assign hs_rise_s = hs_i & ~hs_prev_q;
    assign hs_fall_s = ~hs_i & hs_prev_q;
    assign vs_rise_s = vs_i & ~vs_prev_q;
    assign vs_fall_s = ~vs_i & vs_prev_q;

    // armed_q only rises once vs=0 has been sampled, so a frame already active at reset release is skipped
    assign count_s  = (state_q == S_LINE) & de_i & ~hs_i & vs_i;
    assign close_s  = (state_q == S_LINE) & (hs_rise_s | vs_fall_s);
    assign eof_s    = (state_q != S_IDLE) & vs_fall_s;
    assign trunc_s  = (state_q == S_LINE) & vs_fall_s & ~hs_rise_s;
    assign de_err_s = de_i & (hs_i | ~vs_i) & ((state_q != S_IDLE) | seen_q);
    assign armed_d  = armed_q | ~vs_i;
    assign seen_d   = seen_q | (state_q != S_IDLE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b0;
            armed_q      <= 1'b0;
            seen_q       <= 1'b0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            ref_w_q      <= '0;
            acc_q        <= 32'd0;
            err_q        <= 4'd0;
            frame_w_q    <= '0;
            frame_h_q    <= '0;
            checksum_q   <= 32'd0;
            frame_err_q  <= 4'd0;
            frame_cnt_q  <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_prev_q    <= hs_i;
            vs_prev_q    <= vs_i;
            armed_q      <= armed_d;
            seen_q       <= seen_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            ref_w_q      <= ref_w_d;
            acc_q        <= acc_d;
            err_q        <= err_d;
            frame_w_q    <= frame_w_d;
            frame_h_q    <= frame_h_d;
            checksum_q   <= checksum_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (vs_rise_s && armed_q) state_d = S_FRAME;
                else                      state_d = S_IDLE;
            end
            S_FRAME: begin
                if (vs_fall_s)      state_d = S_IDLE;
                else if (hs_fall_s) state_d = S_FRAME == S_FRAME ? S_LINE : S_LINE;
                else                state_d = S_FRAME;
            end
            S_LINE: begin
                if (vs_fall_s)      state_d = S_IDLE;
                else if (hs_rise_s) state_d = S_FRAME;
                else                state_d = S_LINE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel/line accumulation and end-of-frame reporting
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        ref_w_d      = ref_w_q;
        acc_d        = acc_q;
        err_d        = err_q;
        frame_w_d    = frame_w_q;
        frame_h_d    = frame_h_q;
        checksum_d   = checksum_q;
        frame_err_d  = frame_err_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;

        if (state_q == S_FRAME && hs_fall_s) begin
            pix_cnt_d = '0;
        end else if (count_s) begin
            if (pix_cnt_q == PIX_MAX) begin
                err_d[2] = 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + W_W'(1);
                acc_d     = acc_q + pix_sum(di_i);
            end
        end else begin
            pix_cnt_d = pix_cnt_q;
        end

        // Empty lines (pix_cnt=0) leave geometry untouched
        if (close_s && pix_cnt_q != '0) begin
            if (line_cnt_q == LINE_MAX) err_d[2] = 1'b1;
            else                        line_cnt_d = line_cnt_q + H_W'(1);
            if (line_cnt_q == '0)            ref_w_d  = pix_cnt_q;
            else if (pix_cnt_q != ref_w_q)   err_d[0] = 1'b1;
            else                             ref_w_d  = ref_w_q;
        end else begin
            line_cnt_d = line_cnt_d;
        end

        if (trunc_s) err_d[3] = 1'b1;
        else         err_d[3] = err_d[3];

        if (eof_s) begin
            frame_w_d    = ref_w_d;
            frame_h_d    = line_cnt_d;
            checksum_d   = acc_d;
            frame_err_d  = err_d;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            frame_done_d = 1'b1;
            acc_d        = 32'd0;
            line_cnt_d   = '0;
            ref_w_d      = '0;
            err_d        = 4'd0;
        end else begin
            frame_done_d = 1'b0;
        end

        // Applied after the frame report so blanking-time de errors land in the next frame
        if (de_err_s) err_d[1] = 1'b1;
        else          err_d[1] = err_d[1];
    end

    assign frame_w_o    = frame_w_q;
    assign frame_h_o    = frame_h_q;
    assign checksum_o   = checksum_q;
    assign frame_err_o  = frame_err_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_vstream_meter.sv
// Directed bench for vstream_meter: two instances (default and LINE_SIZE_MAX=8) share one stream;
// a frame-level model predicts each report and a per-cycle process compares it.
module tb_vstream_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] di;
    logic        de, hs, vs;

    logic [12:0] w_a, h_a, h_b;
    logic [3:0]  w_b, err_a, err_b;
    logic [31:0] cs_a, cs_b;
    logic [15:0] cnt_a, cnt_b;
    logic        done_a, done_b;

    vstream_meter dut_a (
        .clk(clk), .rst(rst), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
        .frame_w_o(w_a), .frame_h_o(h_a), .checksum_o(cs_a), .frame_err_o(err_a),
        .frame_cnt_o(cnt_a), .frame_done_o(done_a)
    );

    vstream_meter #(.LINE_SIZE_MAX(8)) dut_b (
        .clk(clk), .rst(rst), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
        .frame_w_o(w_b), .frame_h_o(h_b), .checksum_o(cs_b), .frame_err_o(err_b),
        .frame_cnt_o(cnt_b), .frame_done_o(done_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int w_a, w_b, h_a, h_b, cs_a, cs_b, err_a, err_b, cnt;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   model_cnt = 0;
    int   lens[8];

    function automatic exp_t zero_exp();
        exp_t e;
        e.cyc = 0; e.w_a = 0; e.w_b = 0; e.h_a = 0; e.h_b = 0;
        e.cs_a = 0; e.cs_b = 0; e.err_a = 0; e.err_b = 0; e.cnt = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model's frame reports
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            last = q.pop_front();
            chk("done_a", {31'd0, done_a}, 32'd1);
            chk("done_b", {31'd0, done_b}, 32'd1);
        end else begin
            chk("done_a", {31'd0, done_a}, 32'd0);
            chk("done_b", {31'd0, done_b}, 32'd0);
        end
        chk("w_a", {19'd0, w_a}, last.w_a);
        chk("w_b", {28'd0, w_b}, last.w_b);
        chk("h_a", {19'd0, h_a}, last.h_a);
        chk("h_b", {19'd0, h_b}, last.h_b);
        chk("cs_a", cs_a, last.cs_a);
        chk("cs_b", cs_b, last.cs_b);
        chk("err_a", {28'd0, err_a}, last.err_a);
        chk("err_b", {28'd0, err_b}, last.err_b);
        chk("cnt_a", {16'd0, cnt_a}, last.cnt);
        chk("cnt_b", {16'd0, cnt_b}, last.cnt);
    end

    task automatic send_frame(input int nl, input int gap, input bit trunc, input int trunc_px,
                              input bit same, input bit hs_de, input bit pre_de);
        exp_t e;
        int   lmax, w, h, cs, err, v, n, c;
        bit   first;
        e = zero_exp();
        for (int d = 0; d < 2; d++) begin
            lmax = (d == 0) ? 4096 : 8;
            w = 0; h = 0; cs = 0; err = 0; v = 0; first = 1'b1;
            for (int i = 0; i < nl; i++) begin
                n = (trunc && i == nl - 1) ? trunc_px : lens[i];
                for (int p = 0; p < n; p++) begin
                    v++;
                    if (p < lmax) cs += 3 * v;
                end
                if (n > lmax) err |= 4;
                c = (n > lmax) ? lmax : n;
                if (n > 0) begin
                    h++;
                    if (first) begin w = c; first = 1'b0; end
                    else if (c != w) err |= 1;
                end
            end
            if (trunc) err |= 8;
            if (hs_de || pre_de) err |= 2;
            if (d == 0) begin e.w_a = w; e.h_a = h; e.cs_a = cs; e.err_a = err; end
            else        begin e.w_b = w; e.h_b = h; e.cs_b = cs; e.err_b = err; end
        end
        model_cnt = (model_cnt + 1) % 65536;
        e.cnt = model_cnt;

        repeat (2) @(negedge clk) begin vs = 1'b0; hs = 1'b1; de = 1'b0; end
        if (pre_de) begin
            @(negedge clk) de = 1'b1;
            @(negedge clk) de = 1'b0;
        end
        @(negedge clk) vs = 1'b1;
        @(negedge clk);
        v = 0;
        for (int i = 0; i < nl; i++) begin
            @(negedge clk) hs = 1'b0;
            n = (trunc && i == nl - 1) ? trunc_px : lens[i];
            for (int p = 0; p < n; p++) begin
                @(negedge clk);
                v++;
                de = 1'b1;
                di = {3{8'(v)}};
                for (int g = 1; g < gap; g++) @(negedge clk) de = 1'b0;
            end
            @(negedge clk);
            de = 1'b0;
            if (i == nl - 1 && trunc) begin
                vs = 1'b0;
                e.cyc = cyc + 1;
                q.push_back(e);
            end else if (i == nl - 1 && same) begin
                hs = 1'b1; vs = 1'b0;
                e.cyc = cyc + 1;
                q.push_back(e);
            end else begin
                hs = 1'b1;
                @(negedge clk) if (hs_de && i == 0) de = 1'b1;
                @(negedge clk) de = 1'b0;
            end
        end
        if (!trunc && !same) begin
            @(negedge clk) vs = 1'b0;
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk) begin hs = 1'b1; vs = 1'b0; de = 1'b0; end
        repeat (3) @(negedge clk);
    endtask

    task automatic set_lens(input int a, input int b, input int c);
        lens[0] = a; lens[1] = b; lens[2] = c;
    endtask

    initial begin
        last = zero_exp();
        rst = 1'b0; di = 24'd0; de = 1'b0; hs = 1'b1; vs = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_w", {19'd0, w_a}, 32'd0);
        chk("reset_cs", cs_a, 32'd0);
        chk("reset_cnt", {16'd0, cnt_a}, 32'd0);
        rst = 1'b1;

        // Nominal 4x3, de period 2
        set_lens(4, 4, 4);
        send_frame(3, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("nom_w", {19'd0, w_a}, 32'd4);
        chk("nom_h", {19'd0, h_a}, 32'd3);
        chk("nom_cs", cs_a, 32'd234);
        chk("nom_err", {28'd0, err_a}, 32'd0);
        chk("nom_cnt", {16'd0, cnt_a}, 32'd1);

        // Short second line
        set_lens(4, 3, 4);
        send_frame(3, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("short_err", {28'd0, err_a}, 32'd1);
        chk("short_cs", cs_a, 32'd198);

        // de during hs blanking, then de during vs blanking before next frame
        set_lens(4, 4, 4);
        send_frame(3, 1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("hsde_err", {28'd0, err_a}, 32'd2);
        set_lens(2, 2, 0);
        send_frame(2, 1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("vsde_err", {28'd0, err_a}, 32'd2);

        // Truncated last line; then hs rise with vs fall together
        set_lens(4, 4, 4);
        send_frame(3, 1, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        chk("trunc_err", {28'd0, err_a}, 32'd9);
        chk("trunc_h", {19'd0, h_a}, 32'd3);
        send_frame(3, 1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("same_err", {28'd0, err_a}, 32'd0);

        // Line overflow on the 8-pixel instance
        set_lens(10, 0, 0);
        send_frame(1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("ovf_w_b", {28'd0, w_b}, 32'd8);
        chk("ovf_cs_b", cs_b, 32'd108);
        chk("ovf_err_b", {28'd0, err_b}, 32'd4);
        chk("ovf_cs_a", cs_a, 32'd165);

        // Empty line between two real ones
        set_lens(3, 0, 3);
        send_frame(3, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("empty_h", {19'd0, h_a}, 32'd2);

        // de period 4 gives the nominal result
        set_lens(4, 4, 4);
        send_frame(3, 4, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("gap4_cs", cs_a, 32'd234);
        chk("gap4_cnt", {16'd0, cnt_a}, 32'd9);

        // Reset mid-frame, released while vs=1
        @(negedge clk) vs = 1'b1;
        @(negedge clk) hs = 1'b0;
        @(negedge clk) begin de = 1'b1; di = {3{8'd5}}; end
        @(negedge clk);
        last = zero_exp();
        q.delete();
        model_cnt = 0;
        rst = 1'b0;
        #1;
        chk("rst_mid_cnt", {16'd0, cnt_a}, 32'd0);
        chk("rst_mid_cs", cs_a, 32'd0);
        chk("rst_mid_w", {19'd0, w_a}, 32'd0);
        @(negedge clk) begin de = 1'b0; hs = 1'b1; end
        @(negedge clk) rst = 1'b1;
        @(negedge clk) hs = 1'b0;
        for (int p = 0; p < 3; p++) @(negedge clk) begin de = 1'b1; di = {3{8'd7}}; end
        @(negedge clk) begin de = 1'b0; hs = 1'b1; end
        @(negedge clk) vs = 1'b0;
        repeat (4) @(negedge clk);
        set_lens(4, 4, 4);
        send_frame(3, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_cnt", {16'd0, cnt_a}, 32'd1);
        chk("post_rst_cs", cs_a, 32'd234);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
